// File: rtl/csr_sched_if.sv
// CSR unit port bundle: one op/pc/tval/wdata issue channel toward the CSR
// unit and its read-data / trap-redirect return path.
// master = scheduler side, slave = CSR unit side.
interface csr_sched_if #(
  parameter int XLEN = 64
);
  logic [4:0]      csr_op;
  logic [XLEN-1:0] csr_pc;
  logic [XLEN-1:0] csr_tval;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_is_irq;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_r_valid;
  logic            csr_trap_en;
  logic [XLEN-1:0] csr_trap_pc;

  modport master (
    output csr_op, csr_pc, csr_tval, csr_wdata, csr_is_irq,
    input  csr_rdata, csr_r_valid, csr_trap_en, csr_trap_pc
  );

  modport slave (
    input  csr_op, csr_pc, csr_tval, csr_wdata, csr_is_irq,
    output csr_rdata, csr_r_valid, csr_trap_en, csr_trap_pc
  );
endinterface

// File: rtl/csr_sched.sv
// csr_sched: shares the single CSR/trap unit port between pipeline
// exceptions, pending machine interrupts and CSR/RET instructions.
// One op is issued per grant (ISSUE lasts one cycle); a trap redirect is
// followed by FLUSH_CYCLES cycles of pipeline flush before re-arbitration.
// Optional build macro: CSR_SCHED_IRQ_SYNC_EN adds two-flop synchronisers
// on msip/mtip/meip (two extra cycles of interrupt latency).
//
// Handshake: a requester raises *_valid and holds it (with its payload)
// until the cycle in which its *_ready is high; that cycle is the transfer.
// *_ready is combinational, only ever high in IDLE, and only for the winner.
`ifndef SYSOP_NONE
`define SYSOP_NONE  5'h00
`endif
`ifndef SYSOP_CSR_W
`define SYSOP_CSR_W 5'h01
`endif
`ifndef SYSOP_CSR_S
`define SYSOP_CSR_S 5'h02
`endif
`ifndef SYSOP_CSR_C
`define SYSOP_CSR_C 5'h03
`endif
`ifndef SYSOP_RET
`define SYSOP_RET   5'h04
`endif
`ifndef M_MODE
`define M_MODE      2'b11
`endif

module csr_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  output logic            exc_ready,
  input  logic            ci_valid,
  input  logic [4:0]      ci_op,
  input  logic [11:0]     ci_addr,
  input  logic [XLEN-1:0] ci_wdata,
  input  logic [XLEN-1:0] ci_pc,
  output logic            ci_ready,
  input  logic            msip,
  input  logic            mtip,
  input  logic            meip,
  input  logic [XLEN-1:0] mie_bits,
  input  logic            mstatus_mie,
  input  logic [1:0]      priv,
  csr_sched_if.master     bus,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q;
  logic [XLEN-1:0] pc_q, tval_q, wdata_q;
  logic            irq_q;
  logic [3:0]      cnt_q;
  logic [2:0]      irq_lines;   // {meip, msip, mtip}
  logic [2:0]      pend;
  logic            irq_req;
  logic [3:0]      irq_cause;
  logic            grant_exc, grant_irq, grant_ci;

`ifdef CSR_SCHED_IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;
  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {meip, msip, mtip};
      sync2_q <= sync1_q;
    end
  end
  assign irq_lines = sync2_q;
`else
  assign irq_lines = {meip, msip, mtip};
`endif

  // Only the three machine-level enable bits of mie matter here.
  logic unused_mie;
  assign unused_mie = ^{mie_bits[XLEN-1:12], mie_bits[10:8], mie_bits[6:4], mie_bits[2:0]};

  assign pend      = irq_lines & {mie_bits[11], mie_bits[3], mie_bits[7]};
  assign irq_req   = (|pend) && ((priv != `M_MODE) || mstatus_mie);
  assign irq_cause = pend[2] ? 4'd11 : (pend[1] ? 4'd3 : 4'd7);

  // Next-state, grant and CSR-port outputs.
  always_comb begin
    state_d        = state_q;
    grant_exc      = 1'b0;
    grant_irq      = 1'b0;
    grant_ci       = 1'b0;
    bus.csr_op     = `SYSOP_NONE;
    bus.csr_pc     = '0;
    bus.csr_tval   = '0;
    bus.csr_wdata  = '0;
    bus.csr_is_irq = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (exc_valid)     grant_exc = 1'b1;
          else if (irq_req)  grant_irq = 1'b1;
          else if (ci_valid) grant_ci  = 1'b1;
        end
        if (grant_exc || grant_irq || grant_ci) state_d = ISSUE;
      end
      ISSUE: begin
        bus.csr_op     = op_q;
        bus.csr_pc     = pc_q;
        bus.csr_tval   = tval_q;
        bus.csr_wdata  = wdata_q;
        bus.csr_is_irq = irq_q;
        state_d        = bus.csr_trap_en ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign exc_ready = grant_exc;
  assign ci_ready  = grant_ci;
  assign flush     = (state_q == FLUSH);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, response/redirect capture and flush counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= `SYSOP_NONE;
      pc_q           <= '0;
      tval_q         <= '0;
      wdata_q        <= '0;
      irq_q          <= 1'b0;
      cnt_q          <= 4'd0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      if (grant_exc) begin
        op_q    <= {1'b1, exc_cause};
        pc_q    <= exc_pc;
        tval_q  <= exc_tval;
        wdata_q <= '0;
        irq_q   <= 1'b0;
      end else if (grant_irq) begin
        op_q    <= {1'b1, irq_cause};
        pc_q    <= ci_valid ? ci_pc : exc_pc;
        tval_q  <= '0;
        wdata_q <= '0;
        irq_q   <= 1'b1;
      end else if (grant_ci) begin
        op_q    <= ci_op;
        pc_q    <= ci_pc;
        tval_q  <= {{(XLEN-12){1'b0}}, ci_addr};
        wdata_q <= ci_wdata;
        irq_q   <= 1'b0;
      end
      if (state_q == ISSUE) begin
        if (bus.csr_r_valid) begin
          rsp_rdata <= bus.csr_rdata;
          rsp_valid <= 1'b1;
        end
        if (bus.csr_trap_en) begin
          redirect_pc    <= bus.csr_trap_pc;
          redirect_valid <= 1'b1;
          cnt_q          <= 4'(FLUSH_CYCLES - 1);
        end
      end
      if (state_q == FLUSH && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_csr_sched.sv
// Testbench for csr_sched: randomized and directed requests, a reference
// model of the arbitration rules, and a negedge monitor that compares every
// issued op, read response, redirect and flush window against expectations.
`timescale 1ns/1ps
`ifndef SYSOP_NONE
`define SYSOP_NONE  5'h00
`endif
`ifndef SYSOP_CSR_W
`define SYSOP_CSR_W 5'h01
`endif
`ifndef SYSOP_CSR_S
`define SYSOP_CSR_S 5'h02
`endif
`ifndef SYSOP_CSR_C
`define SYSOP_CSR_C 5'h03
`endif
`ifndef SYSOP_RET
`define SYSOP_RET   5'h04
`endif

module tb_csr_sched;
  localparam int XLEN = 64;
  localparam int FC   = 2;
  localparam int W    = 5 + 3*XLEN + 1;
`ifdef CSR_SCHED_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            exc_valid, exc_ready, ci_valid, ci_ready;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, exc_tval, ci_wdata, ci_pc, mie_bits;
  logic [4:0]      ci_op;
  logic [11:0]     ci_addr;
  logic            msip, mtip, meip, mstatus_mie;
  logic [1:0]      priv, state_dbg;
  logic            rsp_valid, redirect_valid, flush, busy;
  logic [XLEN-1:0] rsp_rdata, redirect_pc;

  csr_sched_if #(.XLEN(XLEN)) bus ();

  csr_sched #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .exc_ready(exc_ready),
    .ci_valid(ci_valid), .ci_op(ci_op), .ci_addr(ci_addr),
    .ci_wdata(ci_wdata), .ci_pc(ci_pc), .ci_ready(ci_ready),
    .msip(msip), .mtip(mtip), .meip(meip), .mie_bits(mie_bits),
    .mstatus_mie(mstatus_mie), .priv(priv), .bus(bus),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] rsp_q[$];
  logic [XLEN-1:0] redir_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic            exc_v;
    logic [3:0]      cause;
    logic [XLEN-1:0] epc, etval;
    logic            ci_v;
    logic [4:0]      op;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata, cpc;
    logic            msip_l, mtip_l, meip_l;
    logic [XLEN-1:0] mie;
    logic            mmie;
    logic [1:0]      prv;
    logic            rv;
    logic [XLEN-1:0] rdata;
    logic            te;
    logic [XLEN-1:0] tpc;
  } txn_t;

  // Reference model: which requester wins and what op record it issues.
  // win: 0 none, 1 exception, 2 interrupt, 3 instruction.
  task automatic model(input txn_t t, output int win, output logic [W-1:0] rec);
    int   causes[3];
    logic lines[3];
    logic enabled;
    causes = '{11, 3, 7};
    lines  = '{t.meip_l, t.msip_l, t.mtip_l};
    enabled = (t.prv != 2'b11) || t.mmie;
    win = 0;
    rec = '0;
    if (t.exc_v) begin
      win = 1;
      rec = {1'b1, t.cause, t.epc, t.etval, {XLEN{1'b0}}, 1'b0};
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (win == 0 && enabled && lines[i] && t.mie[causes[i]]) begin
          win = 2;
          rec = {1'b1, 4'(causes[i]), (t.ci_v ? t.cpc : t.epc),
                 {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b1};
        end
      end
      if (win == 0 && t.ci_v) begin
        win = 3;
        rec = {t.op, t.cpc, {{(XLEN-12){1'b0}}, t.addr}, t.wdata, 1'b0};
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_lines(input txn_t t);
    msip = t.msip_l; mtip = t.mtip_l; meip = t.meip_l;
    mie_bits = t.mie; mstatus_mie = t.mmie; priv = t.prv;
  endtask

  task automatic set_reqs(input txn_t t);
    exc_valid = t.exc_v; exc_cause = t.cause; exc_pc = t.epc; exc_tval = t.etval;
    ci_valid = t.ci_v; ci_op = t.op; ci_addr = t.addr; ci_wdata = t.wdata; ci_pc = t.cpc;
    bus.csr_r_valid = t.rv; bus.csr_rdata = t.rdata;
    bus.csr_trap_en = t.te; bus.csr_trap_pc = t.tpc;
  endtask

  task automatic clear_reqs();
    exc_valid = 1'b0; ci_valid = 1'b0; msip = 1'b0; mtip = 1'b0; meip = 1'b0;
  endtask

  task automatic clear_rsp();
    bus.csr_r_valid = 1'b0; bus.csr_trap_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    check("idle_timeout", busy, 1'b0);
  endtask

  function automatic txn_t zero_txn();
    txn_t t;
    t = '{default: '0};
    t.prv = 2'b11;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    logic [4:0] ops[4];
    ops = '{`SYSOP_CSR_W, `SYSOP_CSR_S, `SYSOP_CSR_C, `SYSOP_RET};
    t.exc_v  = ($urandom_range(0, 3) == 0);
    t.cause  = 4'($urandom);
    t.epc    = {$urandom, $urandom};
    t.etval  = {$urandom, $urandom};
    t.ci_v   = $urandom_range(0, 1) == 1;
    t.op     = ops[$urandom_range(0, 3)];
    t.addr   = 12'($urandom);
    t.wdata  = {$urandom, $urandom};
    t.cpc    = {$urandom, $urandom};
    t.msip_l = ($urandom_range(0, 2) == 0);
    t.mtip_l = ($urandom_range(0, 2) == 0);
    t.meip_l = ($urandom_range(0, 2) == 0);
    t.mie    = {$urandom, $urandom};
    t.mmie   = $urandom_range(0, 1) == 1;
    t.prv    = 2'($urandom_range(0, 3));
    t.rv     = $urandom_range(0, 1) == 1;
    t.rdata  = {$urandom, $urandom};
    t.te     = ($urandom_range(0, 2) == 0);
    t.tpc    = {$urandom, $urandom};
    return t;
  endfunction

  // One complete request: present it, check the ready outputs, queue the
  // expected issue/response/redirect, then wait for the block to go idle.
  task automatic do_txn(input txn_t t);
    int win;
    logic [W-1:0] rec;
    model(t, win, rec);
    @(posedge clk); #2;
    if (IRQ_LAT > 0) begin
      // One-cycle pulse on the lines so the synchronised view is high only
      // in the arbitration cycle.
      set_lines(t);
      @(posedge clk); #2;
      msip = 1'b0; mtip = 1'b0; meip = 1'b0;
      repeat (IRQ_LAT - 1) begin @(posedge clk); #2; end
    end else begin
      set_lines(t);
    end
    set_reqs(t);
    @(negedge clk);
    check("exc_ready", exc_ready, win == 1);
    check("ci_ready", ci_ready, win == 3);
    if (win == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("no_grant_busy", busy, 1'b0);
      end
      @(posedge clk); #2;
      clear_reqs(); clear_rsp();
      repeat (IRQ_LAT + 1) @(posedge clk);
    end else begin
      exp_q.push_back(rec);
      if (t.rv) rsp_q.push_back(t.rdata);
      if (t.te) redir_q.push_back(t.tpc);
      @(posedge clk); #2;
      clear_reqs();
      @(posedge clk); #2;
      clear_rsp();
      wait_idle();
    end
  endtask

  // ---------------- monitor ----------------
  logic         prev_issue = 1'b0;
  logic         mon_issue;
  int           flen = 0;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      prev_issue = 1'b0;
      flen = 0;
    end else begin
      mon_issue = (bus.csr_op != 5'h00);
      if (mon_issue) begin
        check("issue_spacing", prev_issue, 1'b0);
        if (exp_q.size() == 0) check("unexpected_issue", bus.csr_op, 5'h00);
        else begin
          mon_exp = exp_q.pop_front();
          check("issue", {bus.csr_op, bus.csr_pc, bus.csr_tval, bus.csr_wdata, bus.csr_is_irq}, mon_exp);
        end
      end else begin
        check("csr_idle_zero", {bus.csr_pc, bus.csr_tval, bus.csr_wdata, bus.csr_is_irq}, '0);
      end
      if (rsp_valid) begin
        check("rsp_after_issue", prev_issue, 1'b1);
        if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
        else check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      end
      if (redirect_valid) begin
        check("redirect_after_issue", prev_issue, 1'b1);
        check("redirect_flush", flush, 1'b1);
        if (redir_q.size() == 0) check("unexpected_redirect", redirect_valid, 1'b0);
        else check("redirect_pc", redirect_pc, redir_q.pop_front());
      end
      if (flush) begin
        if (flen == 0) check("flush_first_redirect", redirect_valid, 1'b1);
        flen++;
      end else if (flen != 0) begin
        check("flush_len", flen, FC);
        flen = 0;
      end
      prev_issue = mon_issue;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    txn_t t, t2;
    int win, n;
    logic [W-1:0] rec, rec2;
    clear_reqs(); clear_rsp();
    exc_cause = '0; exc_pc = '0; exc_tval = '0; ci_op = '0; ci_addr = '0;
    ci_wdata = '0; ci_pc = '0; mie_bits = '0; mstatus_mie = 1'b0; priv = 2'b11;
    bus.csr_rdata = '0; bus.csr_trap_pc = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {bus.csr_op, busy, flush, rsp_valid, redirect_valid, exc_ready, ci_ready,
           rsp_rdata, redirect_pc, bus.csr_pc, bus.csr_tval, bus.csr_wdata, bus.csr_is_irq},
          '0);

    // Exception with trap redirect.
    t = zero_txn();
    t.exc_v = 1'b1; t.cause = 4'd2; t.epc = 64'h8000_0010; t.etval = 64'h55;
    t.te = 1'b1; t.tpc = 64'h8000_0100;
    do_txn(t);

    // CSR set instruction with read data, no trap.
    t = zero_txn();
    t.ci_v = 1'b1; t.op = `SYSOP_CSR_S; t.addr = 12'h300; t.wdata = 64'h8;
    t.cpc = 64'h8000_0200; t.rv = 1'b1; t.rdata = 64'h1888;
    do_txn(t);

    // Trap with read: response and redirect in the same cycle.
    t = zero_txn();
    t.ci_v = 1'b1; t.op = `SYSOP_CSR_W; t.addr = 12'h180; t.wdata = 64'hABCD;
    t.cpc = 64'h8000_0300; t.rv = 1'b1; t.rdata = 64'h77; t.te = 1'b1; t.tpc = 64'h8000_0304;
    do_txn(t);

    // MEI beats MTI; then globally disabled in M-mode gives no grant.
    t = zero_txn();
    t.meip_l = 1'b1; t.mtip_l = 1'b1; t.mie = 64'h880; t.mmie = 1'b1;
    t.epc = 64'h8000_0400; t.te = 1'b1; t.tpc = 64'h8000_0004;
    do_txn(t);
    t.mmie = 1'b0; t.te = 1'b0;
    do_txn(t);
    t.prv = 2'b00;
    do_txn(t);

    // Exception and instruction together: exception first, instruction
    // held and granted in the first IDLE cycle after the flush.
    t = zero_txn();
    t.exc_v = 1'b1; t.cause = 4'd5; t.epc = 64'h9000_0000; t.etval = 64'h1234;
    t.ci_v = 1'b1; t.op = `SYSOP_CSR_C; t.addr = 12'h340; t.wdata = 64'hF0;
    t.cpc = 64'h9000_0008; t.te = 1'b1; t.tpc = 64'h9000_0100;
    model(t, win, rec);
    t2 = t; t2.exc_v = 1'b0; t2.te = 1'b0;
    model(t2, win, rec2);
    exp_q.push_back(rec); redir_q.push_back(t.tpc); exp_q.push_back(rec2);
    @(posedge clk); #2;
    set_lines(t); set_reqs(t);
    @(negedge clk);
    check("both_exc_ready", exc_ready, 1'b1);
    check("both_ci_ready", ci_ready, 1'b0);
    @(posedge clk); #2; exc_valid = 1'b0;
    @(posedge clk); #2; clear_rsp();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      check("ci_ready_held_low", ci_ready, 1'b0);
      n++;
    end
    check("ci_wait_cycles", n, FC);
    check("ci_ready_after_flush", ci_ready, 1'b1);
    @(posedge clk); #2; ci_valid = 1'b0;
    wait_idle();

    // Reset in the first FLUSH cycle cancels the redirect and flush.
    t = zero_txn();
    t.exc_v = 1'b1; t.cause = 4'd7; t.epc = 64'hA000_0000; t.te = 1'b1; t.tpc = 64'hA000_0040;
    model(t, win, rec);
    exp_q.push_back(rec);
    @(posedge clk); #2; set_reqs(t);
    @(posedge clk); #2; clear_reqs();
    @(posedge clk); #2; clear_rsp(); rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check("rst_flush", flush, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_csr_op", bus.csr_op, 5'h00);
    repeat (4) begin
      @(negedge clk);
      check("rst_no_redirect", redirect_valid, 1'b0);
    end

    // Randomized traffic.
    for (int k = 0; k < 150; k++) do_txn(rand_txn());

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("redir_q_drained", redir_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
